// File: rtl/fir_recover_div.sv
// rtl/fir_recover_div.sv - iterative restoring divider recovering a FIR tap value from its filtered product
//
// Purpose: divides an 18-bit unsigned product word by a 4-bit unsigned tap
// coefficient, one quotient bit per cycle (MSB first). The quotient is
// saturated to 14 bits. Divide-by-zero is flagged instead of computed.
//
// Optional build macro: FIR_RECOVER_DIV_ROUND_EN
//   defined   - the quotient is rounded to nearest before saturation
//   undefined - the quotient is truncated
//
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   synchronous active-high reset
//   start in   1   division request, accepted only when idle
//   fltd  in  18   dividend (filtered product word)
//   coe   in   4   divisor (tap coefficient)
//   busy  out  1   division in progress (RUN or FIN)
//   done  out  1   one-cycle pulse, result outputs valid
//   data  out 14   saturated quotient
//   rem   out  4   remainder
//   ovf   out  1   quotient did not fit in 14 bits
//   dz    out  1   divisor was zero

module fir_recover_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] fltd,
    input  logic [3:0]  coe,
    output logic        busy,
    output logic        done,
    output logic [13:0] data,
    output logic [3:0]  rem,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    // quo starts out holding the dividend; each step shifts a dividend bit
    // out of the top and a quotient bit in at the bottom.
    logic [17:0] quo;
    logic [4:0]  prem;
    logic [3:0]  dvs;
    logic [4:0]  cnt;
    logic        dz_pend;

    logic [4:0]  rem_sh;
    logic        take;
    logic [4:0]  rem_nx;

    logic        round_up;
    logic [18:0] qround;
    logic        sat;

    // One restoring step.
    always_comb begin
        rem_sh = {prem[3:0], quo[17]};
        take   = (rem_sh >= {1'b0, dvs});
        rem_nx = take ? (rem_sh - {1'b0, dvs}) : rem_sh;
    end

`ifdef FIR_RECOVER_DIV_ROUND_EN
    logic [4:0] rem2;
    always_comb begin
        rem2     = {prem[3:0], 1'b0};
        round_up = (rem2 >= {1'b0, dvs});
    end
`else
    always_comb begin
        round_up = 1'b0;
    end
`endif

    // Rounding is applied before the saturation test, so a quotient of
    // 16383 that rounds up overflows.
    always_comb begin
        qround = {1'b0, quo} + {18'd0, round_up};
        sat    = |qround[18:14];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (coe == 4'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt == 5'd0) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo     <= 18'd0;
            prem    <= 5'd0;
            dvs     <= 4'd0;
            cnt     <= 5'd0;
            dz_pend <= 1'b0;
            done    <= 1'b0;
            data    <= 14'd0;
            rem     <= 4'd0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo     <= fltd;
                        dvs     <= coe;
                        prem    <= 5'd0;
                        cnt     <= 5'd17;
                        dz_pend <= (coe == 4'd0);
                    end
                end
                RUN: begin
                    prem <= rem_nx;
                    quo  <= {quo[16:0], take};
                    cnt  <= cnt - 5'd1;
                end
                FIN: begin
                    done <= 1'b1;
                    if (dz_pend) begin
                        data <= 14'h3FFF;
                        rem  <= 4'd0;
                        ovf  <= 1'b0;
                        dz   <= 1'b1;
                    end else begin
                        data <= sat ? 14'h3FFF : qround[13:0];
                        rem  <= prem[3:0];
                        ovf  <= sat;
                        dz   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == FIN);

endmodule

// File: doc/fir_recover_div.md
FIR_RECOVER_DIV -- requirements
Module: fir_recover_div

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to divide; sampled only when idle.
REQ-005 fltd  input  18  unsigned dividend, the filtered product word.
REQ-006 coe  input  4  unsigned divisor, the tap coefficient.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; result outputs valid.
REQ-009 data  output  14  recovered quotient, saturated.
REQ-010 rem  output  4  remainder of fltd / coe.
REQ-011 ovf  output  1  quotient exceeded 14 bits; data saturated.
REQ-012 dz  output  1  coe was zero.

Function
REQ-013 The block SHALL implement an iterative restoring shift-subtract divider, one quotient bit per cycle, MSB first, with an 18-bit internal quotient and a 5-bit partial remainder.
REQ-014 The block SHALL use states IDLE, RUN, FIN.
- IDLE + start=1 + coe!=0 -> RUN: latch fltd/coe, clear the remainder, load the bit counter with 17.
- IDLE + start=1 + coe=0 -> FIN, with dz pending.
- RUN: decrement the counter each cycle; after 18 RUN cycles -> FIN.
- FIN -> IDLE unconditionally.
REQ-015 RUN step: rem' = {rem[3:0], dividend bit}; if rem' >= coe, subtract coe and set the quotient bit to 1; otherwise set the quotient bit to 0.
REQ-016 busy SHALL be 1 exactly while state is RUN or FIN.
REQ-017 start SHALL be ignored while busy=1; no queuing.
REQ-018 In FIN the block SHALL register data, rem, ovf and dz, and set done=1 on the same edge that returns to IDLE.
REQ-019 done SHALL be high for exactly one cycle per accepted start.
REQ-020 Latency: for start sampled at edge N with coe!=0, done SHALL be high in the cycle after edge N+19; with coe=0, in the cycle after edge N+1.
REQ-021 Saturation: if the 18-bit quotient > 16383, then data=14'h3FFF and ovf=1; otherwise data = quotient[13:0] and ovf=0.
REQ-022 Divide-by-zero: data=14'h3FFF, rem=0, ovf=0, dz=1.
REQ-023 data, rem, ovf and dz SHALL hold their values until the next done; they do not change during RUN.
REQ-024 fltd and coe SHALL be don't-care after the start edge; the latched copies are used.

Reset
REQ-025 rst=1 at any edge SHALL force state=IDLE and busy=0, done=0, data=0, rem=0, ovf=0, dz=0, and clear all internal registers.
REQ-026 Reset mid-RUN or in FIN SHALL abort the division with no done pulse.
REQ-027 start coincident with rst=1 SHALL be ignored.

Configuration
REQ-028 Macro FIR_RECOVER_DIV_ROUND_EN:
- Defined: FIN SHALL round data to nearest; if 2*rem >= coe, add 1 to the quotient before the saturation check; rem still reports the true remainder.
- Undefined: data SHALL be the truncated quotient.

Verification
REQ-029 fltd=150, coe=10, start pulse at edge N -> done after edge N+19, data=15, rem=0, ovf=0, dz=0, busy high cycles N+1..N+19.
REQ-030 fltd=155, coe=10 -> rem=5; data=15 with the macro undefined, data=16 with it defined.
REQ-031 fltd=18'h3FFFF, coe=1 -> data=14'h3FFF, ovf=1, rem=0.
REQ-032 fltd=1234, coe=0 -> done after edge N+1, dz=1, data=14'h3FFF, rem=0.
REQ-033 Start at N, second start at N+5 with different operands, rst=1 at N+30 -> only the first division completes (one done); after the N+30 edge all outputs are 0.
REQ-034 Start at N, rst=1 at edge N+8 -> no done pulse; busy=0 from N+8; a new start at N+10 completes normally after edge N+29.
